vshift_sequencer: RTL

//  Sequences one vector shift instruction (vsll/vsrl/vsra) over a vector register, one MAX_WIDTH word at a time.

---
 rtl/vshift_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vshift_sequencer.sv
// Walks one vector shift over a register, one word at a time: READ, EXEC, WRITE (3 cycles/word min), then a DONE pulse.
// Write-back stalls hold wr_* stable with no new reads; flush or reset aborts to IDLE with no done pulse.
module vshift_sequencer #(
  parameter int MIN_WIDTH  = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int SEW_WIDTH  = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
  parameter int VREG_WORDS = 4,
  parameter int VL_W       = $clog2(VREG_WORDS*MAX_WIDTH/MIN_WIDTH)+1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_op,
  input  logic [1:0]                          in_src,
  input  logic [SEW_WIDTH-1:0]                in_sew,
  input  logic [VL_W-1:0]                     in_vl,
  input  logic [4:0]                          in_vs2,
  input  logic [4:0]                          in_vs1,
  input  logic [4:0]                          in_vd,
  input  logic [MAX_WIDTH-1:0]                in_scalar,
  output logic                                rd_en,
  output logic [5+$clog2(VREG_WORDS)-1:0]     rd_addr_a,
  output logic [5+$clog2(VREG_WORDS)-1:0]     rd_addr_b,
  input  logic [MAX_WIDTH-1:0]                rd_data_a,
  input  logic [MAX_WIDTH-1:0]                rd_data_b,
  output logic                                sh_right,
  output logic                                sh_sign,
  output logic [SEW_WIDTH-1:0]                sh_sew,
  output logic [MAX_WIDTH-1:0]                sh_opA,
  output logic [MAX_WIDTH-1:0]                sh_opB,
  input  logic [MAX_WIDTH-1:0]                sh_result,
  output logic                                wr_valid,
  input  logic                                wr_ready,
  output logic [5+$clog2(VREG_WORDS)-1:0]     wr_addr,
  output logic [MAX_WIDTH-1:0]                wr_data,
  output logic [MAX_WIDTH/8-1:0]              wr_be,
  output logic                                done
);
  localparam int WA = $clog2(VREG_WORDS);
  localparam int NB = MAX_WIDTH/8;
  localparam int LB = $clog2(NB);
  localparam int LW = $clog2(MAX_WIDTH);
  localparam int JW = (SEW_WIDTH > 1) ? $clog2(SEW_WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t                 state, state_n;
  logic                   accept;
  logic [WA-1:0]          w, last_w, in_last;
  logic [4:0]             vs2_q, vs1_q, vd_q;
  logic [VL_W-1:0]        vl_q;
  logic [JW-1:0]          j_q, in_j;
  logic                   src_vec_q;
  logic [MAX_WIDTH-1:0]   scal_rep_q, in_rep;
  logic [VL_W:0]          nw_raw, eidx;
  logic [LW-1:0]          fmask;

  // Lowest set bit wins if in_sew is not one-hot.
  always_comb begin
    in_j = '0;
    for (int k = SEW_WIDTH-1; k >= 0; k--)
      if (in_sew[k]) in_j = JW'(k);
  end

  assign nw_raw = ({1'b0, in_vl} + ((VL_W+1)'(1) << in_j) - (VL_W+1)'(1)) >> in_j;

  // Clamp so an oversized vl can never walk into the next register.
  always_comb begin
    if (nw_raw >= (VL_W+1)'(VREG_WORDS)) in_last = WA'(VREG_WORDS-1);
    else                                 in_last = WA'(nw_raw - (VL_W+1)'(1));
  end

  assign fmask = LW'(MAX_WIDTH-1) >> in_j;
  always_comb begin
    in_rep = '0;
    for (int i = 0; i < MAX_WIDTH; i++)
      in_rep[i] = in_scalar[LW'(i) & fmask];
  end

  // Byte enable = owning element index below vl; full words pass trivially.
  always_comb begin
    wr_be = '0;
    eidx  = '0;
    for (int b = 0; b < NB; b++) begin
      eidx     = ((VL_W+1)'(w) << j_q) + ((VL_W+1)'(b) >> (LB - int'(j_q)));
      wr_be[b] = (eidx < {1'b0, vl_q});
    end
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    in_ready = (state == S_IDLE) && !flush;
    rd_en    = (state == S_READ);
    wr_valid = (state == S_WRITE);
    done     = (state == S_DONE);
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) begin
                   accept  = 1'b1;
                   state_n = (in_vl == '0) ? S_DONE : S_READ;
                 end
        S_READ:  state_n = S_EXEC;
        S_EXEC:  state_n = S_WRITE;
        S_WRITE: if (wr_ready) state_n = (w == last_w) ? S_DONE : S_READ;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      w          <= '0;
      last_w     <= '0;
      vs2_q      <= '0;
      vs1_q      <= '0;
      vd_q       <= '0;
      vl_q       <= '0;
      j_q        <= '0;
      src_vec_q  <= 1'b0;
      scal_rep_q <= '0;
      sh_right   <= 1'b0;
      sh_sign    <= 1'b0;
      sh_sew     <= '0;
      sh_opA     <= '0;
      sh_opB     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        w          <= '0;
        last_w     <= in_last;
        vs2_q      <= in_vs2;
        vs1_q      <= in_vs1;
        vd_q       <= in_vd;
        vl_q       <= in_vl;
        j_q        <= in_j;
        src_vec_q  <= (in_src == 2'd0) || (in_src == 2'd3);
        scal_rep_q <= in_rep;
        sh_right   <= (in_op == 2'd1) || (in_op == 2'd2);
        sh_sign    <= (in_op == 2'd2);
        sh_sew     <= in_sew;
      end else if (state == S_WRITE && wr_ready && !flush && w != last_w) begin
        w <= w + 1'b1;
      end
      if (state == S_EXEC && !flush) begin
        sh_opA <= rd_data_a;
        sh_opB <= src_vec_q ? rd_data_b : scal_rep_q;
      end
    end
  end

  assign rd_addr_a = {vs2_q, w};
  assign rd_addr_b = {vs1_q, w};
  assign wr_addr   = {vd_q, w};
  assign wr_data   = sh_result;

endmodule
